// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM encoding, vector count, golden tables.
package truth_table_sweeper_pkg;

  localparam int N_IN_DEF = 4;
  localparam int NVEC     = 2 ** N_IN_DEF;

  localparam logic [NVEC-1:0] F_EQ_D = 16'hAAAA;
  localparam logic [NVEC-1:0] F_EQ_C = 16'hCCCC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Sweep control and result bundle; master = launcher / circuit side, slave = sweeper.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);

  logic                   start;
  logic                   f_in;
  logic [N_IN-1:0]        stim;
  logic                   busy;
  logic                   done;
  logic [(2**N_IN)-1:0]   table_out;
  logic                   pass;
  logic [N_IN:0]          mismatch_cnt;
  logic [N_IN-1:0]        first_fail_idx;

  modport master (
    output start, f_in,
    input  stim, busy, done, table_out, pass, mismatch_cnt, first_fail_idx
  );

  modport slave (
    input  start, f_in,
    output stim, busy, done, table_out, pass, mismatch_cnt, first_fail_idx
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle counter: load clears, en counts up, expire flags the last of SETTLE cycles.
// One flop stage; never blocks, the FSM decides when to count.
module sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination, samples f_in after SETTLE cycles and grades the truth table.
// One vector per SETTLE+1 cycles; start is ignored until the sweep returns to IDLE.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                      N_IN     = N_IN_DEF,
  parameter int                      SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = F_EQ_D
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_sweeper_if.slave   bus
);

  localparam int NV = 2 ** N_IN;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [NV-1:0]     table_q, table_d;
  logic [N_IN:0]     mcnt_q, mcnt_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              pass_q, pass_d;
  logic              settle_expire;

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q != DRIVE),
    .en     ((state_q == DRIVE) && !settle_expire),
    .expire (settle_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DRIVE;
          idx_d   = '0;
          table_d = '0;
          mcnt_d  = '0;
          ffi_d   = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_expire) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = bus.f_in;
        if (bus.f_in != EXPECTED[idx_q]) begin
          // mismatch count still zero means this is the first failing row
          if (mcnt_q == '0) begin
            ffi_d = idx_q;
          end
          mcnt_d = mcnt_q + 1'b1;
        end
        if (idx_q == {N_IN{1'b1}}) begin
          state_d = DONE;
          pass_d  = (table_d == EXPECTED);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      mcnt_q  <= '0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  // stim is the index itself, so it naturally parks on the last vector after a sweep
  assign bus.stim           = idx_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = (state_q == DONE);
  assign bus.table_out      = table_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_cnt   = mcnt_q;
  assign bus.first_fail_idx = ffi_q;

endmodule
